pong_pixel_gen: RTL and testbench
=================================

// Module: pong_pixel_gen
// PURPOSE
// - Pong object/colour stage directly downstream of vga_sync (640x480 timing).
// - Consumes pixel coordinates and video_on from vga_sync. Owns ball and paddle motion state, updated once per frame.
// - Drives registered 12-bit RGB to the board DAC pins.
// PARAMETERS
// - PAD_H    72      paddle height, pixels
// - PAD_V    4       paddle step per frame, pixels
// - BALL_V   2       ball step per frame per axis, pixels
// - C_WALL   12'h00F wall colour
// - C_PAD    12'h0F0 paddle colour
// - C_BALL   12'hF00 ball colour
// - C_BG     12'h000 background colour
// PORTS
// - clk         in   1   system clock, 100 MHz
// - reset       in   1   asynchronous, active-high
// - video_on    in   1   active-area flag from vga_sync
// - p_tick      in   1   pixel-rate enable from vga_sync, 25 MHz
// - x           in   10  pixel column, 0..799
// - y           in   10  pixel row, 0..524
// - btn_up      in   1   raw button, asynchronous to clk
// - btn_down    in   1   raw button, asynchronous to clk
// - rgb         out  12  pixel colour {R4,G4,B4}
// - miss        out  1   one-clk pulse when the ball passes the paddle
// BEHAVIOUR
// - Reset: asynchronous, active-high; clock clk.
//   - Values on reset: rgb=0, miss=0, pad_y=204, ball_x=316, ball_y=236, dx=-, dy=+, sync flops=0.
// - Buttons: 2-flop synchronisers. btn_up and btn_down both high means no paddle movement.
// - refr_tick: registered one-clk pulse the cycle after p_tick && x==0 && y==481 (blanking only).
// - All motion updates happen only on refr_tick. Positions hold between ticks.
// - Paddle (column 600..603, rows pad_y..pad_y+PAD_H-1):
//   - up: pad_y >= PAD_V ? pad_y-PAD_V : 0.
//   - down: pad_y+PAD_H+PAD_V <= 480 ? pad_y+PAD_V : 480-PAD_H.
// - Ball is an 8x8 square with top-left corner at (ball_x, ball_y). Unsigned 10-bit arithmetic.
//   - New velocity is computed first; position then adds the new velocity in the same tick.
//   - ball_y <= BALL_V sets dy=+.
//   - ball_y+8 >= 480-BALL_V sets dy=-.
//   - ball_x <= 36 (left wall, columns 32..35) sets dx=+.
//   - Paddle hit when ball_x+8 is in 600..603 AND ball_y+8 > pad_y AND ball_y < pad_y+PAD_H. Sets dx=-.
//   - Miss when ball_x >= 632. Respawn at (316,236) with dx=-, dy=+. miss=1 for that clk.
//     Miss has priority over all other rules.
//   - Top and paddle hit on the same tick: both direction flips apply.
// - Colour: registered, 1-clk latency from x/y/video_on.
//   - video_on=0 gives 0.
//   - Otherwise priority is ball > paddle > wall > C_BG.
//   - The ball pixel test uses the ball position current at that clk.
// - Reset asserted mid-frame: all state returns to reset values immediately. Motion resumes at the next refr_tick after release.
// CONFIGURATION
// - PONG_MISS_COUNT_EN defined:
//   - Adds output miss_cnt[3:0]: saturating count of misses, reset to 0, holds at 15.
//   - On refr_tick with btn_up && btn_down held, miss_cnt clears to 0.
// - PONG_MISS_COUNT_EN undefined:
//   - Port miss_cnt is absent; no counter logic.
//   - Both buttons held means no paddle movement only.
// TESTING
// - Reset, then video_on=1 at (316,236) -> rgb=C_BALL 1 clk later. Same pixel with video_on=0 -> rgb=0.
// - Step x/y through a frame -> exactly one refr_tick per frame, 1 clk after (0,481) with p_tick.
// - btn_up held 60 frames from pad_y=204 -> pad_y 200,196,...,0, then stays 0.
//   - btn_down held -> pad_y clamps at 408.
// - Force ball_y=2, dy=- -> next tick dy=+, ball_y=4.
//   - ball_x=34, dx=- -> dx=+, ball_x=36.
// - pad_y=200, ball_y=220, ball_x+8=600, dx=+ -> dx=-, ball_x=590. No miss.
// - Paddle moved away, ball_x reaches 632 -> miss pulse 1 clk, ball at (316,236).
//   - With PONG_MISS_COUNT_EN: miss_cnt increments and saturates at 15 after 16 misses.

Source files
------------

// File: rtl/pong_pixel_gen.sv
// pong_pixel_gen: Pong object/colour stage behind vga_sync (640x480).
// Owns the paddle and ball motion state, advanced once per frame on an
// internal refresh pulse, and drives a registered 12-bit {R,G,B} pixel.
// Optional feature macro: PONG_MISS_COUNT_EN adds a saturating miss
// counter output (miss_cnt), cleared by holding both buttons at refresh.
module pong_pixel_gen #(
   parameter logic [9:0]  PAD_H  = 10'd72,
   parameter logic [9:0]  PAD_V  = 10'd4,
   parameter logic [9:0]  BALL_V = 10'd2,
   parameter logic [11:0] C_WALL = 12'h00F,
   parameter logic [11:0] C_PAD  = 12'h0F0,
   parameter logic [11:0] C_BALL = 12'hF00,
   parameter logic [11:0] C_BG   = 12'h000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        video_on,
   input  logic        p_tick,
   input  logic [9:0]  x,
   input  logic [9:0]  y,
   input  logic        btn_up,
   input  logic        btn_down,
   output logic [11:0] rgb,
`ifdef PONG_MISS_COUNT_EN
   output logic [3:0]  miss_cnt,
`endif
   output logic        miss
);

   // Fixed playfield geometry
   localparam logic [9:0] BALL_SZ   = 10'd8;
   localparam logic [9:0] WALL_L    = 10'd32;
   localparam logic [9:0] WALL_R    = 10'd35;
   localparam logic [9:0] WALL_BNC  = 10'd36;
   localparam logic [9:0] PAD_L     = 10'd600;
   localparam logic [9:0] PAD_R     = 10'd603;
   localparam logic [9:0] SCR_H     = 10'd480;
   localparam logic [9:0] X_MISS    = 10'd632;
   localparam logic [9:0] X_START   = 10'd316;
   localparam logic [9:0] Y_START   = 10'd236;
   localparam logic [9:0] PAD_START = 10'd204;
   localparam logic [9:0] REFR_ROW  = 10'd481;

   // Button synchronisers (meta / stable stages)
   logic r_up_m, r_up_s, r_dn_m, r_dn_s;
   // Frame refresh pulse
   logic r_refr_tick;
   // Motion state; r_dx/r_dy: 1 = positive direction
   logic [9:0] r_pad_y, r_ball_x, r_ball_y;
   logic       r_dx, r_dy;
   logic       r_miss;
   logic [11:0] r_rgb;

   // Next-state wires
   logic [9:0] w_pad_y_n, w_ball_x_n, w_ball_y_n;
   logic       w_dx_n, w_dy_n;
   logic       w_hit, w_miss_now;
   logic [9:0] w_ball_r;
   logic       w_ball_on, w_pad_on, w_wall_on;
   logic [11:0] w_rgb_n;

   // Two-flop synchronisers for the asynchronous buttons
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_up_m <= 1'b0;
         r_up_s <= 1'b0;
         r_dn_m <= 1'b0;
         r_dn_s <= 1'b0;
      end else begin
         r_up_m <= btn_up;
         r_up_s <= r_up_m;
         r_dn_m <= btn_down;
         r_dn_s <= r_dn_m;
      end
   end

   // One-clk refresh pulse after the pixel tick at (0,481), inside vertical blanking
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_refr_tick <= 1'b0;
      end else begin
         r_refr_tick <= p_tick && (x == 10'd0) && (y == REFR_ROW);
      end
   end

   // Paddle next position: clamp at the top and bottom of the screen
   always_comb begin
      w_pad_y_n = r_pad_y;
      if (r_up_s && !r_dn_s) begin
         if (r_pad_y >= PAD_V) begin
            w_pad_y_n = r_pad_y - PAD_V;
         end else begin
            w_pad_y_n = 10'd0;
         end
      end else if (r_dn_s && !r_up_s) begin
         if (r_pad_y + PAD_H + PAD_V <= SCR_H) begin
            w_pad_y_n = r_pad_y + PAD_V;
         end else begin
            w_pad_y_n = SCR_H - PAD_H;
         end
      end else begin
         w_pad_y_n = r_pad_y;
      end
   end

   // Ball next velocity first, then position using that new velocity
   always_comb begin
      w_ball_r   = r_ball_x + BALL_SZ;
      w_miss_now = (r_ball_x >= X_MISS);
      w_hit      = (w_ball_r >= PAD_L) && (w_ball_r <= PAD_R) &&
                   (r_ball_y + BALL_SZ > r_pad_y) && (r_ball_y < r_pad_y + PAD_H);
      w_dy_n = r_dy;
      if (r_ball_y <= BALL_V) begin
         w_dy_n = 1'b1;
      end else if (r_ball_y + BALL_SZ >= SCR_H - BALL_V) begin
         w_dy_n = 1'b0;
      end else begin
         w_dy_n = r_dy;
      end
      w_dx_n = r_dx;
      if (r_ball_x <= WALL_BNC) begin
         w_dx_n = 1'b1;
      end else if (w_hit) begin
         w_dx_n = 1'b0;
      end else begin
         w_dx_n = r_dx;
      end
      w_ball_x_n = w_dx_n ? (r_ball_x + BALL_V) : (r_ball_x - BALL_V);
      w_ball_y_n = w_dy_n ? (r_ball_y + BALL_V) : (r_ball_y - BALL_V);
   end

   // Motion state: advances only on the refresh pulse; a miss respawns the ball
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_pad_y  <= PAD_START;
         r_ball_x <= X_START;
         r_ball_y <= Y_START;
         r_dx     <= 1'b0;
         r_dy     <= 1'b1;
         r_miss   <= 1'b0;
      end else if (r_refr_tick) begin
         r_pad_y <= w_pad_y_n;
         if (w_miss_now) begin
            r_ball_x <= X_START;
            r_ball_y <= Y_START;
            r_dx     <= 1'b0;
            r_dy     <= 1'b1;
            r_miss   <= 1'b1;
         end else begin
            r_ball_x <= w_ball_x_n;
            r_ball_y <= w_ball_y_n;
            r_dx     <= w_dx_n;
            r_dy     <= w_dy_n;
            r_miss   <= 1'b0;
         end
      end else begin
         r_miss <= 1'b0;
      end
   end

`ifdef PONG_MISS_COUNT_EN
   logic [3:0] r_miss_cnt;

   // Saturating miss counter; both buttons held at refresh clears it
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_miss_cnt <= 4'd0;
      end else if (r_refr_tick && r_up_s && r_dn_s) begin
         r_miss_cnt <= 4'd0;
      end else if (r_refr_tick && w_miss_now && (r_miss_cnt != 4'd15)) begin
         r_miss_cnt <= r_miss_cnt + 4'd1;
      end else begin
         r_miss_cnt <= r_miss_cnt;
      end
   end

   assign miss_cnt = r_miss_cnt;
`endif

   // Object hit tests for the current pixel against current positions
   always_comb begin
      w_ball_on = (x >= r_ball_x) && (x < r_ball_x + BALL_SZ) &&
                  (y >= r_ball_y) && (y < r_ball_y + BALL_SZ);
      w_pad_on  = (x >= PAD_L) && (x <= PAD_R) &&
                  (y >= r_pad_y) && (y < r_pad_y + PAD_H);
      w_wall_on = (x >= WALL_L) && (x <= WALL_R);
      if (!video_on) begin
         w_rgb_n = 12'h000;
      end else if (w_ball_on) begin
         w_rgb_n = C_BALL;
      end else if (w_pad_on) begin
         w_rgb_n = C_PAD;
      end else if (w_wall_on) begin
         w_rgb_n = C_WALL;
      end else begin
         w_rgb_n = C_BG;
      end
   end

   // Registered colour output to the DAC pins
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rgb <= 12'h000;
      end else begin
         r_rgb <= w_rgb_n;
      end
   end

   assign rgb  = r_rgb;
   assign miss = r_miss;

endmodule

// File: tb/tb_pong_pixel_gen.sv
// Directed bench for pong_pixel_gen: reset state, pixel colours, refresh
// pulse timing, paddle clamping, ball bounces, paddle hit and miss/respawn.
module tb_pong_pixel_gen;

   localparam logic [11:0] C_WALL = 12'h00F;
   localparam logic [11:0] C_PAD  = 12'h0F0;
   localparam logic [11:0] C_BALL = 12'hF00;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        video_on = 1'b0;
   logic        p_tick = 1'b0;
   logic [9:0]  x = 10'd0;
   logic [9:0]  y = 10'd0;
   logic        btn_up = 1'b0;
   logic        btn_down = 1'b0;
   logic [11:0] rgb;
   logic        miss;
`ifdef PONG_MISS_COUNT_EN
   logic [3:0]  miss_cnt;
`endif

   int n_vec = 0;
   int n_err = 0;
   int k = 0;

   pong_pixel_gen dut (
      .clk(clk), .reset(reset), .video_on(video_on), .p_tick(p_tick),
      .x(x), .y(y), .btn_up(btn_up), .btn_down(btn_down), .rgb(rgb),
`ifdef PONG_MISS_COUNT_EN
      .miss_cnt(miss_cnt),
`endif
      .miss(miss)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_vec++;
      if (obs !== exp_v) begin
         n_err++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp_v, exp_v);
      end
   endtask

   task automatic probe(input logic [9:0] px, input logic [9:0] py, input logic von,
                        output logic [11:0] col);
      @(negedge clk);
      x = px; y = py; video_on = von; p_tick = 1'b0;
      @(negedge clk);
      col = rgb;
   endtask

   task automatic tick(output logic m2, output logic m3);
      @(negedge clk);
      x = 10'd0; y = 10'd481; p_tick = 1'b1; video_on = 1'b0;
      @(negedge clk);
      p_tick = 1'b0; x = 10'd5; y = 10'd490;
      @(negedge clk);
      m2 = miss;
      @(negedge clk);
      m3 = miss;
      k++;
   endtask

   task automatic run_to(input int target);
      logic a, b;
      while (k < target) tick(a, b);
   endtask

   task automatic set_btn(input logic u, input logic d);
      @(negedge clk);
      btn_up = u; btn_down = d;
      repeat (3) @(negedge clk);
   endtask

   task automatic check_ball(input string tag, input int bx, input int by);
      logic [11:0] c;
      probe(10'(bx), 10'(by), 1'b1, c);
      chk({tag, "_ul"}, 32'(c == C_BALL), 32'd1);
      probe(10'(bx - 1), 10'(by), 1'b1, c);
      chk({tag, "_left"}, 32'(c == C_BALL), 32'd0);
      probe(10'(bx), 10'(by - 1), 1'b1, c);
      chk({tag, "_above"}, 32'(c == C_BALL), 32'd0);
      probe(10'(bx + 7), 10'(by + 7), 1'b1, c);
      chk({tag, "_lr"}, 32'(c == C_BALL), 32'd1);
   endtask

   task automatic check_pad(input string tag, input int py);
      logic [11:0] c;
      probe(10'd600, 10'(py), 1'b1, c);
      chk({tag, "_top"}, 32'(c), 32'(C_PAD));
      if (py > 0) begin
         probe(10'd600, 10'(py - 1), 1'b1, c);
         chk({tag, "_above"}, 32'(c), 32'd0);
      end
      probe(10'd603, 10'(py + 71), 1'b1, c);
      chk({tag, "_bot"}, 32'(c), 32'(C_PAD));
      probe(10'd600, 10'(py + 72), 1'b1, c);
      chk({tag, "_below"}, 32'(c), 32'd0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [11:0] c;
      logic m2, m3;
      logic exp_t;
      int tot;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_rgb", 32'(rgb), 32'd0);
      chk("rst_miss", 32'(miss), 32'd0);
      reset = 1'b0;

      // Colours at power-up positions
      probe(10'd316, 10'd236, 1'b1, c);
      chk("ball_on", 32'(c), 32'(C_BALL));
      probe(10'd316, 10'd236, 1'b0, c);
      chk("ball_blank", 32'(c), 32'd0);
      probe(10'd33, 10'd100, 1'b1, c);
      chk("wall", 32'(c), 32'(C_WALL));
      probe(10'd300, 10'd100, 1'b1, c);
      chk("bg", 32'(c), 32'd0);
      check_pad("pad_rst", 204);

      // Refresh pulse: exactly one, 1 clk after p_tick at (0,481)
      exp_t = 1'b0;
      tot = 0;
      video_on = 1'b0;
      for (int yy = 479; yy <= 483; yy++) begin
         for (int xx = 0; xx <= 2; xx++) begin
            for (int ph = 0; ph < 4; ph++) begin
               @(negedge clk);
               chk("refr", 32'(dut.r_refr_tick), 32'(exp_t));
               if (dut.r_refr_tick) tot++;
               x = 10'(xx); y = 10'(yy); p_tick = (ph == 0);
               exp_t = p_tick && (xx == 0) && (yy == 481);
            end
         end
      end
      @(negedge clk);
      chk("refr_last", 32'(dut.r_refr_tick), 32'(exp_t));
      if (dut.r_refr_tick) tot++;
      p_tick = 1'b0;
      chk("refr_count", 32'(tot), 32'd1);

      // Fresh start for the motion sequence
      @(negedge clk); reset = 1'b1;
      @(negedge clk); reset = 1'b0;
      k = 0;

      // Paddle up, clamps at 0
      set_btn(1'b1, 1'b0);
      run_to(1);   check_pad("up1", 200);
      run_to(2);   check_pad("up2", 196);
      run_to(51);  check_pad("up51", 0);
      run_to(60);  check_pad("up60", 0);
      check_ball("ball60", 196, 356);

      // Paddle down, clamps at 408; ball bounces off bottom then left wall
      set_btn(1'b0, 1'b1);
      run_to(61);  check_pad("dn61", 4);
      run_to(117); check_ball("ball117", 82, 470);
      run_to(118); check_ball("bot_bounce", 80, 468);
      run_to(140); check_ball("ball140", 36, 424);
      run_to(141); check_ball("wall_bounce", 38, 422);
      run_to(162); check_pad("dn162", 408);
      run_to(165); check_pad("dn165", 408);

      // Paddle to 100, then both buttons held: no movement
      set_btn(1'b1, 1'b0);
      run_to(242); check_pad("up242", 100);
      set_btn(1'b1, 1'b1);
      run_to(245); check_pad("both", 100);
      set_btn(1'b0, 1'b0);

      // Top bounce, then paddle hit
      run_to(351); check_ball("ball351", 458, 2);
      run_to(352); check_ball("top_bounce", 460, 4);
      run_to(418); check_ball("ball418", 592, 136);
      tick(m2, m3);
      chk("hit_nomiss", 32'(m2), 32'd0);
      check_ball("pad_hit", 590, 138);

      // Asynchronous reset mid-frame (rgb currently showing the ball)
      #2 reset = 1'b1;
      #1;
      chk("midrst_rgb", 32'(rgb), 32'd0);
      chk("midrst_miss", 32'(miss), 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      k = 0;
      check_ball("midrst_ball", 316, 236);
      check_pad("midrst_pad", 204);

      // Paddle left at 204: ball passes it and is missed
      run_to(438); check_ball("ball438", 632, 176);
      tick(m2, m3);
      chk("miss_pulse", 32'(m2), 32'd1);
      chk("miss_len", 32'(m3), 32'd0);
      check_ball("respawn", 316, 236);
`ifdef PONG_MISS_COUNT_EN
      chk("miss_cnt", 32'(miss_cnt), 32'd1);
`endif
      run_to(440); check_ball("respawn_dir", 314, 238);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
